// File: rtl/incomp_if2_pkg.sv
// Shared types and constants for the synchronized incomplete-if selector.
package incomp_if2_pkg;

  // Which branch produced y on a given cycle.
  typedef logic [1:0] src_t;

  localparam src_t SRC_HOLD = 2'b00;
  localparam src_t SRC_I0   = 2'b01;
  localparam src_t SRC_I2   = 2'b10;

  // Deepest synchronizer chain the selector is meant to be built with.
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/incomp_if2_sync_sync_bit.sv
// One-bit synchronizer with a parameterized number of flops.
// DEPTH=0 degenerates to a wire so the select register samples the pin itself.
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [DEPTH-1:0] ff;

      // Shift the async input through the flop chain; every stage clears on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ff <= '0;
        end else begin
          ff[0] <= d;
          for (int k = 1; k < DEPTH; k++) begin
            ff[k] <= ff[k-1];
          end
        end
      end

      assign q = ff[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/incomp_if2_sync.sv
// Clocked priority selector: i0 branch beats i2 branch, otherwise y holds in an
// explicit register. Reports the active branch and a saturating hold counter.
module incomp_if2_sync
  import incomp_if2_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0,
  parameter int   CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  output logic             y,
  output src_t             src,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic s0, s1, s2, s3;

  // Each bit is synchronized on its own; no cross-bit coherency is attempted.
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_i0 (.clk(clk), .rst_n(rst_n), .d(i0), .q(s0));
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_i1 (.clk(clk), .rst_n(rst_n), .d(i1), .q(s1));
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_i2 (.clk(clk), .rst_n(rst_n), .d(i2), .q(s2));
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_i3 (.clk(clk), .rst_n(rst_n), .d(i3), .q(s3));

  // Priority select with explicit hold register and saturating hold-cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= RESET_VAL;
      src      <= SRC_HOLD;
      hold_cnt <= '0;
    end else if (s0) begin
      y        <= s1;
      src      <= SRC_I0;
      hold_cnt <= '0;
    end else if (s2) begin
      y        <= s3;
      src      <= SRC_I2;
      hold_cnt <= '0;
    end else begin
      src <= SRC_HOLD;
      if (hold_cnt != CNT_MAX) begin
        hold_cnt <= hold_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_incomp_if2_sync.sv
// Bench for incomp_if2_sync: directed steps plus a cycle model feeding a
// scoreboard queue. Time unit is nominal 100 ps: clock period 100 units.
module tb_incomp_if2_sync;

  localparam int T_HALF = 50;

  logic       clk;
  logic       rst_n;
  logic       i0, i1, i2, i3;
  logic       y, y4;
  logic [1:0] src, src4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;

  int checks   = 0;
  int failures = 0;

  incomp_if2_sync dut (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .y(y), .src(src), .hold_cnt(cnt8)
  );

  incomp_if2_sync #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .y(y4), .src(src4), .hold_cnt(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #T_HALF clk = ~clk;
  end

  // Reference model: two-stage delay of {i3,i2,i1,i0}, then priority/hold rule.
  typedef struct packed {
    logic       y;
    logic [1:0] src;
    logic [7:0] c8;
    logic [3:0] c4;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] m_st0, m_st1;
  sb_t        m_cur, m_nxt;

  always_comb begin
    m_nxt     = m_cur;
    m_nxt.src = 2'b00;
    m_nxt.c8  = (m_cur.c8 == 8'hFF) ? m_cur.c8 : m_cur.c8 + 8'd1;
    m_nxt.c4  = (m_cur.c4 == 4'hF)  ? m_cur.c4 : m_cur.c4 + 4'd1;
    if (m_st1[0]) begin
      m_nxt.y   = m_st1[1];
      m_nxt.src = 2'b01;
      m_nxt.c8  = 8'd0;
      m_nxt.c4  = 4'd0;
    end else if (m_st1[2]) begin
      m_nxt.y   = m_st1[3];
      m_nxt.src = 2'b10;
      m_nxt.c8  = 8'd0;
      m_nxt.c4  = 4'd0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st0 <= 4'b0;
      m_st1 <= 4'b0;
      m_cur <= '0;
      sb.push_back(sb_t'(0));
    end else begin
      m_st0 <= {i3, i2, i1, i0};
      m_st1 <= m_st0;
      m_cur <= m_nxt;
      sb.push_back(m_nxt);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare the DUT with the model entry for the last edge.
  task automatic cycle();
    sb_t e;
    @(negedge clk);
    check("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_y", y, e.y);
      check("sb_src", src, e.src);
      check("sb_cnt8", cnt8, e.c8);
      check("sb_cnt4", cnt4, e.c4);
      check("sb_y4", y4, e.y);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    i0 = 1'b1; i1 = 1'b1; i2 = 1'b1; i3 = 1'b1;

    // Reset held with all inputs high.
    cycles(3);
    check("rst_y", y, 1'b0);
    check("rst_src", src, 2'b00);
    check("rst_cnt", cnt8, 8'd0);

    rst_n = 1'b1;
    cycles(3);
    check("rel_y", y, 1'b1);
    check("rel_src", src, 2'b01);

    // i0 dominates i2.
    i1 = 1'b0;
    cycles(3);
    check("prio_y0", y, 1'b0);
    check("prio_src", src, 2'b01);
    i1 = 1'b1;
    cycles(3);
    check("prio_y1", y, 1'b1);

    // i2 branch follows i3.
    i0 = 1'b0; i2 = 1'b1; i3 = 1'b0;
    cycles(10);
    check("i2_y0", y, 1'b0);
    check("i2_src", src, 2'b10);
    i3 = 1'b1;
    cycles(10);
    check("i2_y1", y, 1'b1);
    i3 = 1'b0;
    cycles(10);
    check("i2_y0b", y, 1'b0);
    i3 = 1'b1;
    cycles(10);
    check("i2_y1b", y, 1'b1);

    // Hold: data inputs wiggle, y stays, counter climbs.
    i2 = 1'b0;
    cycles(3);
    check("hold_cnt1", cnt8, 8'd1);
    for (int k = 2; k <= 5; k++) begin
      i1 = ~i1; i3 = ~i3;
      cycle();
      check("hold_y", y, 1'b1);
      check("hold_src", src, 2'b00);
      check("hold_cnt", cnt8, k);
    end

    // Saturation on the 4-bit counter; 8-bit keeps counting.
    cycles(20);
    check("sat_cnt4", cnt4, 4'd15);
    check("sat_cnt8", cnt8, 8'd25);
    i0 = 1'b1; i1 = 1'b1;
    cycles(3);
    check("clr_cnt4", cnt4, 4'd0);
    check("clr_cnt8", cnt8, 8'd0);
    check("clr_y", y, 1'b1);

    // Asynchronous reset mid-operation takes effect without a clock edge.
    #20 rst_n = 1'b0;
    #10;
    check("arst_y", y, 1'b0);
    check("arst_src", src, 2'b00);
    check("arst_cnt", cnt8, 8'd0);
    cycle();
    rst_n = 1'b1;
    cycles(2);
    check("arst_pre_y", y, 1'b0);
    cycles(1);
    check("arst_post_y", y, 1'b1);
    check("arst_post_src", src, 2'b01);

    // Free-running inputs at non-harmonic periods; toggles land off the clock grid.
    #5;
    fork
      repeat (9)  begin #3170 i0 = ~i0; end
      repeat (81) begin #370  i1 = ~i1; end
      repeat (19) begin #1570 i2 = ~i2; end
      repeat (44) begin #670  i3 = ~i3; end
    join_none
    cycles(305);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/incomp_if2_sync.md
Name: incomp_if2_sync

Overview:
- Clocked, glitch-free replacement for the incomplete-if priority selector `incomp_if2`.
- Combinational intent of the original:
  - i0=1 → y follows i1.
  - else i2=1 → y follows i3.
  - else y holds its previous value.
- Here the hold is an explicit register, not an inferred latch.
- Inputs arrive asynchronously and are synchronized before selection.
- Also reports which branch drove y and how long y has been holding.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per input bit. Legal range 0..4; 0 means inputs are sampled directly by the select register.
- RESET_VAL, 1'b0, value of y after reset.
- CNT_W, 8, width of the saturating hold-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i0  input  1  primary select (asynchronous).
- i1  input  1  data selected when i0=1.
- i2  input  1  secondary select (asynchronous).
- i3  input  1  data selected when i0=0 and i2=1.
- y  output  1  registered selected/held data.
- src  output  2  branch that produced y this cycle: 2'b01 = i0 branch, 2'b10 = i2 branch, 2'b00 = hold.
- hold_cnt  output  CNT_W  consecutive cycles in hold, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release via clk):
  - y=RESET_VAL, src=2'b00, hold_cnt=0.
  - All synchronizer flops are 0.
- Synchronization:
  - Each of i0..i3 passes through its own SYNC_STAGES-deep flop chain, giving s0..s3.
  - No cross-bit coherency is guaranteed; a bit changing near a clock edge may resolve one cycle late.
- Selection, registered each rising edge, on the synchronized inputs:
  - s0=1: y←s1, src←01, hold_cnt←0.
  - else s2=1: y←s3, src←10, hold_cnt←0.
  - else: y unchanged, src←00, hold_cnt←hold_cnt+1, saturating at 2^CNT_W−1.
- Priority: s0 dominates s2 when both are 1.
- Latency: SYNC_STAGES+1 clk cycles from a stable input change to y/src/hold_cnt (3 cycles at the default).
- Holding: y keeps the last value written by a branch, or RESET_VAL if no branch has been active since reset.
- Reset mid-operation: outputs return to reset values immediately. Synchronizer contents are discarded, so the first post-reset selection uses freshly synchronized inputs after SYNC_STAGES+1 edges.
- Structure: no latches, no combinational path from i* to any output.

Decomposition:
- Package incomp_if2_pkg:
  - SRC_HOLD=2'b00, SRC_I0=2'b01, SRC_I2=2'b10.
  - typedef src_t (2 bits).
- Sub-module sync_bit: one-bit, parameterized-depth synchronizer with asynchronous active-low reset. Instantiated four times.
- Selection and counter logic live in the top module.

Test Plan:
- Reset: hold rst_n=0 with i0..i3=1 → y=0, src=00, hold_cnt=0. Release; after 3 edges → y=1, src=01.
- i0 priority: i0=1, i2=1, i1=0, i3=1 → after 3 cycles y=0, src=01. Toggle i1 to 1 → y=1 three cycles later.
- i2 branch: i0=0, i2=1, i3 toggles 0→1→0 on successive 10-cycle windows → y tracks i3 with 3-cycle lag, src=10.
- Hold: drive y=1 via the i2 branch, then i0=0, i2=0, toggle i1/i3 freely → y stays 1, src=00, hold_cnt counts 1,2,3…
- Saturation: CNT_W=4, hold for 20 cycles → hold_cnt reaches 15 and stays. Then set i0=1 → hold_cnt=0.
- Asynchronous stimulus: i0/i1/i2/i3 toggling at non-harmonic periods 317/37/157/67 ns, clk 10 ns, for 3000 ns → a cycle-accurate model of the priority/hold rule on the 2-stage-delayed inputs matches y every cycle. No X after reset.
